// File: rtl/key_pkg.sv
// Shared definitions for the multi-channel key conditioner.
// Contents:
//   SYNC_STAGES : depth of the per-key input synchroniser
//   key_st_e    : per-key event FSM states
//   ms_to_cyc   : converts a millisecond duration into clk cycles
package key_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } key_st_e;

  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz,
                                            input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: synchroniser, debounce counter, event FSM and hold counter.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   key_in         : raw asynchronous key pin
//   key_state      : debounced level, 1 = pressed
//   press_pulse    : 1-cycle pulse on accepted press
//   release_pulse  : 1-cycle pulse on accepted release
//   long_pulse     : 1-cycle pulse once per press after LONG_CYC cycles held
//   repeat_pulse   : 1-cycle pulse every REP_CYC cycles after long_pulse
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DB_CYC     = 10,
  parameter int unsigned LONG_CYC   = 50,
  parameter int unsigned REP_CYC    = 20,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned DBW      = $clog2(DB_CYC + 1);
  localparam int unsigned HOLD_MAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int unsigned HW       = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYC - 1);
  // When an event is disabled its terminal value is never compared.
  localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0]  REP_LAST  = HW'(REP_CYC - 1);
  localparam bit LONG_EN  = (LONG_CYC != 0);
  localparam bit REP_EN   = LONG_EN && (REP_CYC != 0);
  localparam logic IDLE_LVL = ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p;
  logic [DBW-1:0]         db_cnt;
  logic                   db_level;

  key_st_e        state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           press_d, release_d, long_d, repeat_d;

  // Synchroniser presets to the released level so a key held through
  // reset is seen as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{IDLE_LVL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
  end

  assign p = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (p == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= ~db_level;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RELEASED;
      hold_q        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
    end
  end

  // Release has priority over a long/repeat terminal count in the same cycle.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      RELEASED: begin
        if (db_level) begin
          state_d = PRESSED;
          hold_d  = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (!db_level) begin
          state_d   = RELEASED;
          hold_d    = '0;
          release_d = 1'b1;
        end else if (LONG_EN) begin
          if (hold_q == LONG_LAST) begin
            state_d = HELD;
            hold_d  = '0;
            long_d  = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      HELD: begin
        if (!db_level) begin
          state_d   = RELEASED;
          hold_d    = '0;
          release_d = 1'b1;
        end else if (REP_EN) begin
          if (hold_q == REP_LAST) begin
            hold_d   = '0;
            repeat_d = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = RELEASED;
        hold_d  = '0;
      end
    endcase
  end

  assign key_state = (state_q != RELEASED);

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: per-key synchronise, debounce and
// press/release/long/repeat event generation, plus an any-event flag.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   key_in         : raw asynchronous key pins [N_KEYS]
//   key_state      : debounced levels, 1 = pressed [N_KEYS]
//   press_pulse    : press events [N_KEYS]
//   release_pulse  : release events [N_KEYS]
//   long_pulse     : long-press events [N_KEYS]
//   repeat_pulse   : auto-repeat events [N_KEYS]
//   any_event      : OR of all event pulses
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS      = 3,
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              any_event
);

  localparam int unsigned DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
  localparam int unsigned REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);

  if (DB_CYC < 2) begin : g_db_too_short
    $error("key_debounce_multi: debounce interval must be at least 2 cycles");
  end
  if ((N_KEYS < 1) || (N_KEYS > 16)) begin : g_bad_n_keys
    $error("key_debounce_multi: N_KEYS must be in 1..16");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_channel #(
      .DB_CYC     (DB_CYC),
      .LONG_CYC   (LONG_CYC),
      .REP_CYC    (REP_CYC),
      .ACTIVE_LOW (ACTIVE_LOW != 0)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_in        (key_in[i]),
      .key_state     (key_state[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  assign any_event = (|press_pulse) | (|release_pulse) | (|long_pulse) | (|repeat_pulse);

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi. Three instances share stimulus:
//   d0: LONG 50 / REP 20, d1: long disabled, d2: repeat disabled.
// A run-length/age model predicts all outputs every cycle; literal
// latency and event-count checks pin the model.
module tb_key_debounce_multi;

  localparam int DB = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_in = 3'b111;

  logic [2:0] st_o [3];
  logic [2:0] pr_o [3];
  logic [2:0] rl_o [3];
  logic [2:0] lg_o [3];
  logic [2:0] rp_o [3];
  logic       any_o [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [2:0] key_smp = 3'b111;
  logic       smp_ok  = 1'b0;

  always #5 clk = ~clk;

  key_debounce_multi #(.N_KEYS(3), .CLK_HZ(10_000), .DEBOUNCE_MS(1), .LONG_MS(5),
                       .REPEAT_MS(2), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_state(st_o[0]),
    .press_pulse(pr_o[0]), .release_pulse(rl_o[0]), .long_pulse(lg_o[0]),
    .repeat_pulse(rp_o[0]), .any_event(any_o[0]));

  key_debounce_multi #(.N_KEYS(3), .CLK_HZ(10_000), .DEBOUNCE_MS(1), .LONG_MS(0),
                       .REPEAT_MS(2), .ACTIVE_LOW(1)) dut_nolong (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_state(st_o[1]),
    .press_pulse(pr_o[1]), .release_pulse(rl_o[1]), .long_pulse(lg_o[1]),
    .repeat_pulse(rp_o[1]), .any_event(any_o[1]));

  key_debounce_multi #(.N_KEYS(3), .CLK_HZ(10_000), .DEBOUNCE_MS(1), .LONG_MS(5),
                       .REPEAT_MS(0), .ACTIVE_LOW(1)) dut_norep (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_state(st_o[2]),
    .press_pulse(pr_o[2]), .release_pulse(rl_o[2]), .long_pulse(lg_o[2]),
    .repeat_pulse(rp_o[2]), .any_event(any_o[2]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int long_of(input int d);
    return (d == 1) ? 0 : 50;
  endfunction

  function automatic int rep_of(input int d);
    return (d == 2) ? 0 : 20;
  endfunction

  always @(posedge clk) begin
    key_smp <= key_in;
    smp_ok  <= rst_n;
    cyc     <= cyc + 1;
  end

  // Model: a level is accepted once the pressed-normalised input has held a
  // value different from the accepted level for DB consecutive samples; it is
  // visible 3 cycles later. Long/repeat follow from the age since press.
  bit         run_val [3][3];
  int         run_len [3][3];
  bit         lvl     [3][3];
  logic [3:0] lh      [3][3];
  int         age     [3][3];

  initial begin : model_cmp
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        logic [2:0] st, pr, rl, lg, rp;
        st = '0; pr = '0; rl = '0; lg = '0; rp = '0;
        for (int c = 0; c < 3; c++) begin
          if (!rst_n) begin
            run_val[d][c] = 1'b0;
            run_len[d][c] = 0;
            lvl[d][c]     = 1'b0;
            lh[d][c]      = '0;
            age[d][c]     = 0;
          end else if (smp_ok) begin
            bit q, prv, now;
            int lc, rc;
            lc = long_of(d);
            rc = rep_of(d);
            q  = ~key_smp[c];
            if (q == run_val[d][c]) run_len[d][c]++;
            else begin
              run_val[d][c] = q;
              run_len[d][c] = 1;
            end
            if (run_val[d][c] != lvl[d][c] && run_len[d][c] >= DB) lvl[d][c] = run_val[d][c];
            prv = lh[d][c][3];
            lh[d][c] = {lh[d][c][2:0], lvl[d][c]};
            now = lh[d][c][3];
            pr[c] = now & ~prv;
            rl[c] = ~now & prv;
            if (pr[c]) age[d][c] = 0;
            else if (now) age[d][c]++;
            lg[c] = now && !pr[c] && (lc > 0) && (age[d][c] == lc);
            rp[c] = now && (lc > 0) && (rc > 0) && (age[d][c] > lc) &&
                    (((age[d][c] - lc) % rc) == 0);
          end
          st[c] = lh[d][c][3];
        end
        check($sformatf("dut%0d outputs {any,state,press,release,long,repeat}", d),
              32'({any_o[d], st_o[d], pr_o[d], rl_o[d], lg_o[d], rp_o[d]}),
              32'({(|{pr, rl, lg, rp}), st, pr, rl, lg, rp}));
      end
    end
  end

  // Event log for literal checks.
  int n_p [3][3], n_r [3][3], n_l [3][3], n_q [3][3];
  int t_p [3][3], t_r [3][3], t_l [3][3], t_qf [3][3], t_ql [3][3];
  int n_any [3];

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        for (int c = 0; c < 3; c++) begin
          if (pr_o[d][c]) begin n_p[d][c]++; t_p[d][c] = cyc; end
          if (rl_o[d][c]) begin n_r[d][c]++; t_r[d][c] = cyc; end
          if (lg_o[d][c]) begin n_l[d][c]++; t_l[d][c] = cyc; end
          if (rp_o[d][c]) begin
            if (n_q[d][c] == 0) t_qf[d][c] = cyc;
            n_q[d][c]++;
            t_ql[d][c] = cyc;
          end
        end
        if (any_o[d]) n_any[d]++;
      end
    end
  end

  task automatic clear_counts();
    for (int d = 0; d < 3; d++) begin
      n_any[d] = 0;
      for (int c = 0; c < 3; c++) begin
        n_p[d][c] = 0; n_r[d][c] = 0; n_l[d][c] = 0; n_q[d][c] = 0;
        t_p[d][c] = -1; t_r[d][c] = -1; t_l[d][c] = -1; t_qf[d][c] = -1; t_ql[d][c] = -1;
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t0;

  initial begin : stim
    clear_counts();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d reset outputs", d),
            32'({any_o[d], st_o[d], pr_o[d], rl_o[d], lg_o[d], rp_o[d]}), 32'd0);
    end
    #2 rst_n = 1'b1;
    wait_cyc(5);

    // Clean press and release on key 0
    clear_counts();
    key_in[0] = 1'b0;
    t0 = cyc;
    wait_cyc(12);
    check("key0 state before accept", 32'(st_o[0][0]), 32'd0);
    wait_cyc(1);
    check("key0 state after accept", 32'(st_o[0][0]), 32'd1);
    wait_cyc(7);
    check("key0 press latency", 32'(t_p[0][0] - t0), 32'd13);
    check("key0 press count", 32'(n_p[0][0]), 32'd1);
    key_in[0] = 1'b1;
    t0 = cyc;
    wait_cyc(20);
    check("key0 release latency", 32'(t_r[0][0] - t0), 32'd13);
    check("key0 release count", 32'(n_r[0][0]), 32'd1);
    check("key0 short hold no long", 32'(n_l[0][0]), 32'd0);

    // Bounce on key 1: 4-cycle toggles, finally low
    clear_counts();
    for (int i = 0; i <= 10; i++) begin
      key_in[1] = (i % 2) != 0;
      t0 = cyc;
      if (i < 10) wait_cyc(4);
    end
    check("key1 quiet during bounce", 32'(n_p[0][1] + n_r[0][1]), 32'd0);
    wait_cyc(25);
    check("key1 bounce press count", 32'(n_p[0][1]), 32'd1);
    check("key1 press after last toggle", 32'(t_p[0][1] - t0), 32'd13);
    check("key1 no release", 32'(n_r[0][1]), 32'd0);
    key_in[1] = 1'b1;
    wait_cyc(20);

    // Long hold on key 2 for 200 cycles
    clear_counts();
    key_in[2] = 1'b0;
    t0 = cyc;
    wait_cyc(200);
    key_in[2] = 1'b1;
    wait_cyc(20);
    check("key2 press latency", 32'(t_p[0][2] - t0), 32'd13);
    check("key2 long after press", 32'(t_l[0][2] - t_p[0][2]), 32'd50);
    check("key2 long count", 32'(n_l[0][2]), 32'd1);
    check("key2 first repeat after long", 32'(t_qf[0][2] - t_l[0][2]), 32'd20);
    check("key2 repeat count", 32'(n_q[0][2]), 32'd7);
    check("key2 repeat span", 32'(t_ql[0][2] - t_qf[0][2]), 32'd120);
    check("key2 release latency", 32'(t_r[0][2] - t0), 32'd213);
    check("nolong press count", 32'(n_p[1][2]), 32'd1);
    check("nolong long count", 32'(n_l[1][2]), 32'd0);
    check("nolong repeat count", 32'(n_q[1][2]), 32'd0);
    check("nolong release count", 32'(n_r[1][2]), 32'd1);
    check("norep long count", 32'(n_l[2][2]), 32'd1);
    check("norep repeat count", 32'(n_q[2][2]), 32'd0);

    // Simultaneous press on keys 0 and 2
    clear_counts();
    key_in = 3'b010;
    t0 = cyc;
    wait_cyc(20);
    check("simul key0 press latency", 32'(t_p[0][0] - t0), 32'd13);
    check("simul key2 press latency", 32'(t_p[0][2] - t0), 32'd13);
    check("simul any_event cycles", 32'(n_any[0]), 32'd1);
    key_in[0] = 1'b1;
    wait_cyc(50);
    check("key2 held before reset", 32'(st_o[0][2]), 32'd1);

    // Reset mid-hold with key 2 still pressed
    clear_counts();
    #2 rst_n = 1'b0;
    #1;
    check("mid-hold reset outputs", 32'({any_o[0], st_o[0], pr_o[0], rl_o[0], lg_o[0], rp_o[0]}), 32'd0);
    wait_cyc(3);
    #2 rst_n = 1'b1;
    t0 = cyc;
    wait_cyc(25);
    check("reset no release", 32'(n_r[0][2]), 32'd0);
    check("re-press count", 32'(n_p[0][2]), 32'd1);
    check("re-press latency", 32'(t_p[0][2] - t0), 32'd13);

    key_in = 3'b111;
    wait_cyc(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
